counter_cmd_gen: RTL and testbench
==================================

Name: counter_cmd_gen

Overview:
Upstream command stage for the 6-bit up/down/load counter register. It converts asynchronous up/down button levels and a synchronous load request into the counter's single-cycle inc/dec/ld strobes and load value.
- Synchronises both buttons and edge-detects them.
- Auto-repeats when a button is held.
- Applies ld > inc > dec priority so the counter never sees conflicting strobes.

Parameters:
WIDTH, 6, counter/load data width
HOLD_DLY, 8, cycles from first pulse to first auto-repeat pulse (>=1)
RPT_PER, 4, cycles between auto-repeat pulses (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-low reset
up_btn  input  1  asynchronous up-button level
dn_btn  input  1  asynchronous down-button level
ld_req  input  1  single-cycle load request, clk domain
ld_data  input  WIDTH  load value, valid with ld_req
cnt  input  WIDTH  current counter value (feedback, used by optional feature)
inc  output  1  one-cycle increment strobe
dec  output  1  one-cycle decrement strobe
ld  output  1  one-cycle load strobe
ld_val  output  WIDTH  registered load value

Behaviour:
- Reset: rst low at a rising clk edge clears every flop.
  - inc=0, dec=0, ld=0, ld_val=0.
  - Synchroniser flops = 0, FSM = IDLE, timer = 0.
  - Reset mid-hold aborts the repeat. A button still held when rst rises looks like a fresh rising edge and produces one pulse after the normal latency.
- Synchronisation: each button passes through 2 flops (s1, s2). Rising edge = s2 & ~s2_q.
- Outputs: inc, dec, ld and ld_val are registered.
  - Button latency: a button high before edge N gives inc/dec high after edge N+2, i.e. 3 edges. High for exactly 1 cycle.
  - ld latency: ld_req high at edge N gives ld=1 and ld_val=ld_data after edge N, for 1 cycle.
- FSM states: IDLE, DELAY, REPEAT. Register dir in {UP, DN}. Down-counter timer of width $clog2(max(HOLD_DLY,RPT_PER)+1).
- IDLE:
  - Rising edge of up with dn_s2=0 -> emit inc, dir=UP, timer=HOLD_DLY-1, go to DELAY. Down is symmetric (emit dec, dir=DN).
  - Both rising on the same cycle, or the other button already high -> no pulse, stay in IDLE.
- DELAY:
  - Active button low or the other button high -> IDLE, no pulse.
  - Else timer==0 -> emit pulse for dir, timer=RPT_PER-1, go to REPEAT.
  - Else timer decrements.
- REPEAT: same release/abort check as DELAY. timer==0 -> emit pulse, reload RPT_PER-1. Else decrement.
- Priority: a cycle with ld_req forces inc=dec=0.
  - A button pulse due that cycle is dropped, not deferred.
  - The FSM and timer advance normally.
  - inc and dec are never both 1; at most one of inc/dec/ld is 1 in any cycle.
- Width: ld_val takes ld_data unmodified. No arithmetic on data; the counter owns the wrap.

Optional Feature:
CNT_CMD_SAT_EN
- Defined: inc is suppressed when cnt == all-ones (63); dec is suppressed when cnt == 0. Suppression is evaluated on the cycle the pulse would be registered. The FSM still advances, so a held button at the limit keeps timing but emits nothing.
- Undefined: cnt is ignored and pulses are emitted regardless, so the counter wraps 63->0 and 0->63.

Decomposition:
- Package counter_cmd_pkg:
  - state enum {IDLE, DELAY, REPEAT}
  - dir enum {UP, DN}
  - CNT_W = 6 default
  - SYNC_STAGES = 2 constant
- One natural sub-module, btn_sync_edge: 2-flop synchroniser plus edge detector with ports clk, rst, d, lvl, rise. Instantiated twice, for up and down.

Test Plan:
1. Reset: rst=0 for 2 cycles with buttons toggling -> inc=dec=ld=0, ld_val=0 throughout; FSM in IDLE.
2. Tap: up_btn high for 3 cycles then low -> exactly one inc, 3 edges after assertion; dec=0.
3. Hold: up_btn held 30 cycles, HOLD_DLY=8, RPT_PER=4 -> inc at t0, t0+8, t0+12, t0+16, ...; stops within 3 cycles of release.
4. Load collision: hold dn_btn and pulse ld_req with ld_data=6'd42 on the cycle a repeat dec is due -> ld=1, ld_val=42, dec=0 that cycle; the next dec arrives RPT_PER cycles later.
5. Both buttons: raise up_btn and dn_btn together -> no inc/dec. While holding up in REPEAT, raise dn -> pulses stop, FSM goes to IDLE.
6. With CNT_CMD_SAT_EN: cnt=63 plus up tap -> inc stays 0; cnt=0 plus down tap -> dec stays 0. Without the macro, both pulses appear.

Source files
------------

// File: rtl/counter_cmd_gen_pkg.sv
// ============================================================================
// Module  : counter_cmd_pkg
// Brief   : Shared types and constants for the counter command generator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_t;

  localparam int CNT_W       = 6;
  localparam int SYNC_STAGES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_cmd_gen_if.sv
// ============================================================================
// Module  : counter_cmd_gen_if
// Brief   : Button / load inputs and strobe outputs of the command generator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface counter_cmd_gen_if
  import counter_cmd_pkg::*;
#(
  parameter int WIDTH = CNT_W
);
  logic             up_btn;
  logic             dn_btn;
  logic             ld_req;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] cnt;
  logic             inc;
  logic             dec;
  logic             ld;
  logic [WIDTH-1:0] ld_val;

  // master is the command generator; slave is the counter/environment side
  modport master (
    input  up_btn, dn_btn, ld_req, ld_data, cnt,
    output inc, dec, ld, ld_val
  );

  modport slave (
    output up_btn, dn_btn, ld_req, ld_data, cnt,
    input  inc, dec, ld, ld_val
  );
endinterface

`default_nettype wire

// File: rtl/counter_cmd_gen_btn_sync_edge.sv
// ============================================================================
// Module  : btn_sync_edge
// Brief   : Multi-flop synchroniser for an async level plus rising-edge detect.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_sync_edge
  import counter_cmd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      lvl_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~lvl_q;

endmodule

`default_nettype wire

// File: rtl/counter_cmd_gen.sv
// ============================================================================
// Module  : counter_cmd_gen
// Brief   : Turns async up/down buttons (with auto-repeat) and a load request
//           into exclusive inc/dec/ld strobes. Optional CNT_CMD_SAT_EN stops
//           inc at all-ones and dec at zero.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_cmd_gen
  import counter_cmd_pkg::*;
#(
  parameter int WIDTH    = CNT_W,
  parameter int HOLD_DLY = 8,
  parameter int RPT_PER  = 4
)(
  input  logic               clk,
  input  logic               rst,
  counter_cmd_gen_if.master  bus
);

  localparam int               TMR_W   = $clog2(max_int(HOLD_DLY, RPT_PER) + 1);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_DLY - 1);
  localparam logic [TMR_W-1:0] RPT_LD  = TMR_W'(RPT_PER - 1);

  logic             up_lvl, up_rise, dn_lvl, dn_rise;
  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             fire_up, fire_dn;
  logic             act_lvl, oth_lvl;
  logic             at_max, at_min;

  btn_sync_edge u_up_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.up_btn),
    .lvl  (up_lvl),
    .rise (up_rise)
  );

  btn_sync_edge u_dn_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.dn_btn),
    .lvl  (dn_lvl),
    .rise (dn_rise)
  );

`ifdef CNT_CMD_SAT_EN
  assign at_max = (bus.cnt == {WIDTH{1'b1}});
  assign at_min = (bus.cnt == '0);
`else
  assign at_max = 1'b0;
  assign at_min = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      dir_q   <= UP;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    fire_up = 1'b0;
    fire_dn = 1'b0;
    act_lvl = (dir_q == UP) ? up_lvl : dn_lvl;
    oth_lvl = (dir_q == UP) ? dn_lvl : up_lvl;
    case (state_q)
      IDLE: begin
        // the other level being high also covers both buttons rising together
        if (up_rise && !dn_lvl) begin
          fire_up = 1'b1;
          dir_d   = UP;
          timer_d = HOLD_LD;
          state_d = DELAY;
        end else if (dn_rise && !up_lvl) begin
          fire_dn = 1'b1;
          dir_d   = DN;
          timer_d = HOLD_LD;
          state_d = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!act_lvl || oth_lvl) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          fire_up = (dir_q == UP);
          fire_dn = (dir_q == DN);
          timer_d = RPT_LD;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a load in the same cycle drops any button pulse; it is never deferred
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.inc    <= 1'b0;
      bus.dec    <= 1'b0;
      bus.ld     <= 1'b0;
      bus.ld_val <= '0;
    end else begin
      bus.inc <= fire_up & ~bus.ld_req & ~at_max;
      bus.dec <= fire_dn & ~bus.ld_req & ~at_min;
      bus.ld  <= bus.ld_req;
      if (bus.ld_req) begin
        bus.ld_val <= bus.ld_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_cmd_gen.sv
// ============================================================================
// Module  : tb_counter_cmd_gen
// Brief   : Directed self-checking bench for counter_cmd_gen (8/4 timing).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counter_cmd_gen;

`ifdef CNT_CMD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  counter_cmd_gen_if #(.WIDTH(6)) bus ();

  counter_cmd_gen #(
    .WIDTH    (6),
    .HOLD_DLY (8),
    .RPT_PER  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] b(input logic x);
    return {31'b0, x};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_inc", b(bus.inc), 0);
      check("idle_dec", b(bus.dec), 0);
      check("idle_ld",  b(bus.ld),  0);
    end
  endtask

  // tap one button for 3 cycles; pulse expected on the 3rd edge when enabled
  task automatic tap(input logic is_up, input logic exp_pulse, input string tag);
    if (is_up) bus.up_btn = 1'b1; else bus.dn_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check(tag, b(is_up ? bus.inc : bus.dec), b(exp_pulse && k == 3));
      check("tap_other", b(is_up ? bus.dec : bus.inc), 0);
      if (k == 3) begin
        bus.up_btn = 1'b0;
        bus.dn_btn = 1'b0;
      end
    end
  endtask

  initial begin
    int n_inc;
    rst         = 1'b0;
    bus.up_btn  = 1'b0;
    bus.dn_btn  = 1'b0;
    bus.ld_req  = 1'b1;
    bus.ld_data = 6'd42;
    bus.cnt     = 6'd10;

    // reset with buttons toggling and a load request pending
    for (int k = 0; k < 2; k++) begin
      bus.up_btn = ~bus.up_btn;
      bus.dn_btn = bus.up_btn;
      step();
      check("rst_inc",    b(bus.inc), 0);
      check("rst_dec",    b(bus.dec), 0);
      check("rst_ld",     b(bus.ld),  0);
      check("rst_ld_val", 32'(bus.ld_val), 0);
    end
    bus.up_btn = 1'b0;
    bus.dn_btn = 1'b0;
    bus.ld_req = 1'b0;
    step();
    rst = 1'b1;
    idle(6);

    // single tap
    tap(1'b1, 1'b1, "tap_inc");
    idle(4);

    // hold up for 30 cycles: pulses at 3, 11, 15, ..., 31
    bus.up_btn = 1'b1;
    n_inc = 0;
    for (int k = 1; k <= 36; k++) begin
      step();
      check("hold_inc", b(bus.inc), b(k == 3 || (k >= 11 && k <= 31 && ((k - 11) % 4) == 0)));
      check("hold_dec", b(bus.dec), 0);
      if (bus.inc === 1'b1) n_inc++;
      if (k == 30) bus.up_btn = 1'b0;
    end
    check("hold_count", 32'(n_inc), 7);
    idle(4);

    // hold down; load collides with the repeat dec due at edge 15
    bus.dn_btn  = 1'b1;
    bus.ld_data = 6'd42;
    for (int k = 1; k <= 24; k++) begin
      step();
      check("col_dec", b(bus.dec), b(k == 3 || k == 11 || k == 19));
      check("col_ld",  b(bus.ld),  b(k == 15));
      check("col_inc", b(bus.inc), 0);
      if (k == 15) begin
        check("col_ld_val", 32'(bus.ld_val), 42);
        bus.ld_req  = 1'b0;
        bus.ld_data = 6'd5;
      end
      if (k == 14) bus.ld_req = 1'b1;
      if (k == 20) bus.dn_btn = 1'b0;
    end
    check("ld_val_hold", 32'(bus.ld_val), 42);
    idle(4);

    // both buttons together: nothing
    bus.up_btn = 1'b1;
    bus.dn_btn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("both_inc", b(bus.inc), 0);
      check("both_dec", b(bus.dec), 0);
    end
    bus.up_btn = 1'b0;
    bus.dn_btn = 1'b0;
    idle(5);

    // up in REPEAT, then dn rises: repeat aborts before edge 19
    bus.up_btn = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      check("abort_inc", b(bus.inc), b(k == 3 || k == 11 || k == 15));
      check("abort_dec", b(bus.dec), 0);
      if (k == 16) bus.dn_btn = 1'b1;
      if (k == 20) begin
        bus.up_btn = 1'b0;
        bus.dn_btn = 1'b0;
      end
    end
    idle(4);

    // limits: suppressed only with saturation and only in the matching direction
    bus.cnt = 6'd63;
    tap(1'b1, !SAT, "sat_hi_inc");
    idle(3);
    tap(1'b0, 1'b1, "sat_hi_dec");
    idle(3);
    bus.cnt = 6'd0;
    tap(1'b0, !SAT, "sat_lo_dec");
    idle(3);
    tap(1'b1, 1'b1, "sat_lo_inc");
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
